// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared opcodes, unit count and sequencer state type for the FPU
package fpu_pkg;

    localparam int NUM_UNITS       = 5;
    localparam int DEFAULT_TIMEOUT = 64;

    localparam logic [2:0] OPC_U0 = 3'd0;
    localparam logic [2:0] OPC_U1 = 3'd1;
    localparam logic [2:0] OPC_U2 = 3'd2;
    localparam logic [2:0] OPC_U3 = 3'd3;
    localparam logic [2:0] OPC_U4 = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/fpu_watchdog.sv
// rtl/fpu_watchdog.sv - loadable up-counter with clear/enable and terminal-count flag
module fpu_watchdog #(
    parameter int TIMEOUT = 64,
    parameter int CW      = $clog2(TIMEOUT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    input  logic          en_i,
    output logic          tc_o
);

    localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/fpu_op_sequencer.sv
// rtl/fpu_op_sequencer.sv - single-outstanding start/done sequencer for the FPU arithmetic units
module fpu_op_sequencer #(
    parameter int W         = 32,
    parameter int NUM_UNITS = fpu_pkg::NUM_UNITS,
    parameter int TIMEOUT   = fpu_pkg::DEFAULT_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [2:0]             req_opc,
    input  logic [W-1:0]           req_a,
    input  logic [W-1:0]           req_b,
    output logic [W-1:0]           op_a,
    output logic [W-1:0]           op_b,
    output logic [NUM_UNITS-1:0]   start,
    input  logic [NUM_UNITS-1:0]   unit_done,
    input  logic [NUM_UNITS*W-1:0] unit_result,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [W-1:0]           rsp_result,
    output logic                   rsp_err,
    output logic                   busy
);

    import fpu_pkg::*;

    seq_state_e state_q, state_d;
    logic [2:0]           opc_q, opc_d;
    logic [W-1:0]         op_a_q, op_a_d, op_b_q, op_b_d;
    logic [NUM_UNITS-1:0] start_q, start_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [W-1:0]         rsp_result_q, rsp_result_d;
    logic                 rsp_err_q, rsp_err_d;

    logic         accept, opc_legal;
    logic         sel_done;
    logic [W-1:0] sel_result;
    logic         wd_clr, wd_en, wd_tc;

    assign req_ready = rst_n && (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign accept    = req_valid && req_ready;
    assign opc_legal = (32'(req_opc) < 32'(NUM_UNITS));

    // Only the unit named by the latched opcode can complete the operation.
    always_comb begin
        sel_done   = 1'b0;
        sel_result = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (opc_q == 3'(i)) begin
                sel_done   = unit_done[i];
                sel_result = unit_result[i*W +: W];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        opc_d        = opc_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;
        wd_clr       = 1'b0;
        wd_en        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    opc_d  = req_opc;
                    op_a_d = req_a;
                    op_b_d = req_b;
                    if (opc_legal) begin
                        state_d = ISSUE;
                    end else begin
                        rsp_result_d = '0;
                        rsp_err_d    = 1'b1;
                        state_d      = RESP;
                    end
                end
            end
            ISSUE: begin
                wd_clr  = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                wd_en = 1'b1;
                // A done coinciding with terminal count still wins.
                if (sel_done) begin
                    rsp_result_d = sel_result;
                    rsp_err_d    = 1'b0;
                    state_d      = RESP;
                end else if (wd_tc) begin
                    rsp_result_d = '0;
                    rsp_err_d    = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        start_d = '0;
        if (state_d == ISSUE) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                start_d[i] = (opc_d == 3'(i));
            end
        end
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            opc_q        <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            start_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            opc_q        <= opc_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            start_q      <= start_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    fpu_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (wd_clr),
        .load_i    (1'b0),
        .load_val_i('0),
        .en_i      (wd_en),
        .tc_o      (wd_tc)
    );

    assign op_a       = op_a_q;
    assign op_b       = op_b_q;
    assign start      = start_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// tb/tb_fpu_op_sequencer.sv - scoreboard bench for fpu_op_sequencer
module tb_fpu_op_sequencer;

    import fpu_pkg::*;

    localparam int W          = 32;
    localparam int NU         = 5;
    localparam int TB_TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_opc;
    logic [W-1:0]      req_a, req_b;
    logic [W-1:0]      op_a, op_b;
    logic [NU-1:0]     start;
    logic [NU-1:0]     unit_done;
    logic [NU*W-1:0]   unit_result;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [W-1:0]      rsp_result;
    logic              rsp_err;
    logic              busy;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [W:0]   sb_q[$];
    logic [W-1:0] unit_res[NU];

    always #5 clk = ~clk;

    fpu_op_sequencer #(
        .W(W), .NUM_UNITS(NU), .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_opc(req_opc),
        .req_a(req_a), .req_b(req_b), .op_a(op_a), .op_b(op_b),
        .start(start), .unit_done(unit_done), .unit_result(unit_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy)
    );

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] opc, input logic [W-1:0] a, input logic [W-1:0] b);
        req_valid = 1'b1;
        req_opc   = opc;
        req_a     = a;
        req_b     = b;
        expect_eq("req_ready_before_send", 64'(req_ready), 64'd1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int budget);
        int n = 0;
        while (!rsp_valid && n < budget) begin
            step();
            n++;
        end
        if (!rsp_valid) expect_eq("rsp_wait_expired", 64'd0, 64'd1);
    endtask

    // Scoreboard: one entry popped per response handshake.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                expect_eq("sb_unexpected_rsp", 64'(sb_q.size()), 64'd1);
            end else begin
                expect_eq("rsp", 64'({rsp_err, rsp_result}), 64'(sb_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] a, b;
        int d;

        unit_res[0] = 32'hA000_0000;
        unit_res[1] = 32'hA111_1111;
        unit_res[2] = 32'h4040_0000;
        unit_res[3] = 32'hA333_3333;
        unit_res[4] = 32'hA444_4444;
        for (int i = 0; i < NU; i++) unit_result[i*W +: W] = unit_res[i];

        rst_n     = 1'b0;
        req_valid = 1'b1;
        req_opc   = OPC_U2;
        req_a     = 32'h1234_5678;
        req_b     = 32'h9ABC_DEF0;
        rsp_ready = 1'b1;
        unit_done = '0;

        for (int i = 0; i < 3; i++) begin
            step();
            expect_eq("rst_req_ready", 64'(req_ready), 64'd0);
            expect_eq("rst_start", 64'(start), 64'd0);
            expect_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            expect_eq("rst_rsp_result", 64'(rsp_result), 64'd0);
            expect_eq("rst_busy", 64'(busy), 64'd0);
            expect_eq("rst_op_a", 64'(op_a), 64'd0);
        end
        req_valid = 1'b0;
        rst_n     = 1'b1;
        #1;
        expect_eq("release_req_ready", 64'(req_ready), 64'd1);

        // Legal op on unit 2 with a one-cycle unit.
        send(OPC_U2, 32'h3F80_0000, 32'h4000_0000);
        sb_q.push_back({1'b0, 32'h4040_0000});
        expect_eq("legal_start", 64'(start), 64'b00100);
        expect_eq("legal_busy", 64'(busy), 64'd1);
        expect_eq("legal_req_ready", 64'(req_ready), 64'd0);
        step();
        expect_eq("legal_start_cleared", 64'(start), 64'd0);
        expect_eq("legal_rsp_early", 64'(rsp_valid), 64'd0);
        unit_done = 5'b00100;
        step();
        unit_done = '0;
        expect_eq("legal_rsp_valid", 64'(rsp_valid), 64'd1);
        expect_eq("legal_op_a", 64'(op_a), 64'h3F80_0000);
        expect_eq("legal_op_b", 64'(op_b), 64'h4000_0000);
        step();
        expect_eq("legal_back_idle", 64'(req_ready), 64'd1);

        // Illegal opcode responds immediately without a start pulse.
        send(3'd6, 32'h1111_1111, 32'h2222_2222);
        sb_q.push_back({1'b1, 32'h0});
        expect_eq("illegal_start", 64'(start), 64'd0);
        expect_eq("illegal_rsp_valid", 64'(rsp_valid), 64'd1);
        expect_eq("illegal_err", 64'(rsp_err), 64'd1);
        expect_eq("illegal_result", 64'(rsp_result), 64'd0);
        step();

        // Timeout on unit 4 with a stray done from unit 1.
        send(OPC_U4, 32'h5555_5555, 32'h6666_6666);
        sb_q.push_back({1'b1, 32'h0});
        expect_eq("to_start", 64'(start), 64'b10000);
        for (int k = 0; k < TB_TIMEOUT; k++) begin
            step();
            expect_eq("to_rsp_early", 64'(rsp_valid), 64'd0);
            unit_done = (k == 3) ? 5'b00010 : 5'b00000;
        end
        unit_done = '0;
        step();
        expect_eq("to_rsp_valid", 64'(rsp_valid), 64'd1);
        expect_eq("to_err", 64'(rsp_err), 64'd1);
        step();

        // Backpressure holds the response for 10 cycles.
        rsp_ready = 1'b0;
        send(OPC_U1, 32'h7777_0001, 32'h8888_0002);
        sb_q.push_back({1'b0, unit_res[1]});
        step();
        unit_done = 5'b00010;
        step();
        unit_done = '0;
        for (int i = 0; i < 10; i++) begin
            expect_eq("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            expect_eq("bp_rsp", 64'({rsp_err, rsp_result}), 64'({1'b0, unit_res[1]}));
            expect_eq("bp_req_ready", 64'(req_ready), 64'd0);
            expect_eq("bp_op_a", 64'(op_a), 64'h7777_0001);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        expect_eq("bp_no_same_cycle_ready", 64'(req_ready), 64'd0);
        step();
        expect_eq("bp_req_ready_after", 64'(req_ready), 64'd1);
        expect_eq("bp_rsp_dropped", 64'(rsp_valid), 64'd0);

        // Reset during WAIT drops the operation; a late done is ignored.
        send(OPC_U0, 32'hDEAD_0000, 32'hBEEF_0000);
        step();
        rst_n = 1'b0;
        step();
        rst_n     = 1'b1;
        unit_done = 5'b00001;
        #1;
        expect_eq("mrst_busy", 64'(busy), 64'd0);
        expect_eq("mrst_req_ready", 64'(req_ready), 64'd1);
        step();
        unit_done = '0;
        expect_eq("mrst_rsp_valid", 64'(rsp_valid), 64'd0);
        expect_eq("mrst_busy2", 64'(busy), 64'd0);
        step();
        expect_eq("mrst_rsp_valid2", 64'(rsp_valid), 64'd0);

        send(OPC_U3, 32'h0BAD_F00D, 32'hCAFE_0003);
        sb_q.push_back({1'b0, unit_res[3]});
        step();
        step();
        unit_done = 5'b01000;
        step();
        unit_done = '0;
        expect_eq("post_rst_rsp_valid", 64'(rsp_valid), 64'd1);
        step();

        // Every unit with random operands and varied done latency.
        for (int u = 0; u < NU; u++) begin
            a = $urandom;
            b = $urandom;
            d = $urandom_range(0, 3);
            send(3'(u), a, b);
            sb_q.push_back({1'b0, unit_res[u]});
            expect_eq("sweep_start", 64'(start), 64'(1) << u);
            step();
            repeat (d) step();
            unit_done = NU'(1) << u;
            step();
            unit_done = '0;
            wait_rsp(4);
            expect_eq("sweep_op_a", 64'(op_a), 64'(a));
            expect_eq("sweep_op_b", 64'(op_b), 64'(b));
            step();
        end

        step();
        expect_eq("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
